// File: rtl/ex_muldiv_unit.sv
// Iterative EX-stage multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, behind a valid/ready handshake, feeding the ALU DivOut path.
module ex_muldiv_unit #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic [2:0]      div_sel,
    input  logic            is_word,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);
    localparam int DW = 2 * XLEN;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic            word_q, word_d;
    logic            neg_q, neg_d;
    logic            rneg_q, rneg_d;
    logic [6:0]      cnt_q, cnt_d;
    logic [DW-1:0]   mcand_q, mcand_d;
    logic [XLEN-1:0] opb_q, opb_d;
    logic [DW-1:0]   acc_q, acc_d;
    logic [XLEN-1:0] res_q, res_d;

    function automatic logic [XLEN-1:0] sext_w(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction

    // Operand conditioning for the accept cycle
    logic            word_op, a_signed, b_signed, a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0] dvd_val, a_ext, b_ext, a_abs, b_abs;

    always_comb begin
        word_op  = is_word && (div_sel == 3'd0 || div_sel[2]);
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (div_sel)
            3'd0, 3'd1, 3'd4, 3'd6: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            3'd2:    a_signed = 1'b1;
            default: ;
        endcase
        dvd_val  = word_op ? sext_w(src1[31:0]) : src1;
        a_ext    = (word_op && !a_signed) ? {{(XLEN-32){1'b0}}, src1[31:0]} : dvd_val;
        b_ext    = word_op ? (b_signed ? sext_w(src2[31:0]) : {{(XLEN-32){1'b0}}, src2[31:0]})
                           : src2;
        a_neg    = a_signed & a_ext[XLEN-1];
        b_neg    = b_signed & b_ext[XLEN-1];
        a_abs    = a_neg ? -a_ext : a_ext;
        b_abs    = b_neg ? -b_ext : b_ext;
        div_zero = div_sel[2] && (b_ext == '0);
        div_ovf  = div_sel[2] && !div_sel[0] && (b_ext == '1) &&
                   (a_ext == (word_op ? sext_w(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}}));
    end

    // One iteration step plus the sign-corrected final value used on the last step
    logic [DW-1:0]   acc_step, prod, div_step;
    logic [XLEN:0]   shl_rem;
    logic            fit;
    logic [XLEN-1:0] rem_sub, quot, rem, q_sgn, r_sgn, fin;

    always_comb begin
        acc_step = acc_q + (opb_q[0] ? mcand_q : '0);
        shl_rem  = mcand_q[DW-1:XLEN-1];
        fit      = (shl_rem >= {1'b0, opb_q});
        rem_sub  = shl_rem[XLEN-1:0] - opb_q;
        div_step = {fit ? rem_sub : shl_rem[XLEN-1:0], mcand_q[XLEN-2:0], fit};
        prod     = neg_q ? -acc_step : acc_step;
        quot     = div_step[XLEN-1:0];
        rem      = div_step[DW-1:XLEN];
        q_sgn    = neg_q ? -quot : quot;
        r_sgn    = rneg_q ? -rem : rem;
        case (op_q)
            3'd0:             fin = word_q ? sext_w(prod[31:0]) : prod[XLEN-1:0];
            3'd1, 3'd2, 3'd3: fin = prod[DW-1:XLEN];
            3'd4, 3'd5:       fin = word_q ? sext_w(q_sgn[31:0]) : q_sgn;
            default:          fin = word_q ? sext_w(r_sgn[31:0]) : r_sgn;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        word_d  = word_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d   = div_sel;
                    word_d = word_op;
                    neg_d  = a_neg ^ b_neg;
                    rneg_d = a_neg;
                    cnt_d  = '0;
                    acc_d  = '0;
                    opb_d  = b_abs;
                    // W-form dividends sit at the top of the low half so 32 shifts consume them
                    mcand_d = (div_sel[2] && word_op)
                            ? {{XLEN{1'b0}}, a_abs[31:0], {(XLEN-32){1'b0}}}
                            : {{XLEN{1'b0}}, a_abs};
                    if (div_zero) begin
                        res_d   = div_sel[1] ? dvd_val : '1;
                        state_d = DONE;
                    end else if (div_ovf) begin
                        res_d   = div_sel[1] ? '0 : dvd_val;
                        state_d = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (op_q[2]) begin
                    mcand_d = div_step;
                end else begin
                    acc_d   = acc_step;
                    mcand_d = mcand_q << 1;
                    opb_d   = opb_q >> 1;
                end
                cnt_d = cnt_q + 7'd1;
                if (cnt_q == (word_q ? 7'd31 : 7'(XLEN - 1))) begin
                    state_d = DONE;
                    res_d   = fin;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
            res_d   = res_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            word_q  <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            cnt_q   <= '0;
            mcand_q <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            word_q  <= word_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = res_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed and random bench for ex_muldiv_unit, checked against an arithmetic reference model.
module tb_ex_muldiv_unit;

    logic        clk, rst, in_valid, in_ready, is_word, flush, out_valid, out_ready;
    logic [63:0] src1, src2, result;
    logic [2:0]  div_sel;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [63:0] exp_res = '0;
    logic [63:0] last_res = '0;

    ex_muldiv_unit #(.XLEN(64)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .src1(src1), .src2(src2), .div_sel(div_sel), .is_word(is_word),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .result(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, want 0x%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] sx32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // Reference: full-width products and native truncating division
    function automatic logic [63:0] model(input logic [2:0] sel, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] sa, sb, ua, ub, p;
        int s32a, s32b;
        int unsigned u32a, u32b;
        longint s64a, s64b;
        longint unsigned u64a, u64b;
        logic [31:0] t32;
        logic [63:0] t64;
        sa = {{64{a[63]}}, a};
        sb = {{64{b[63]}}, b};
        ua = {64'd0, a};
        ub = {64'd0, b};
        case (sel)
            3'd0: begin p = sa * sb; return w ? sx32(p[31:0]) : p[63:0]; end
            3'd1: begin p = sa * sb; return p[127:64]; end
            3'd2: begin p = sa * ub; return p[127:64]; end
            3'd3: begin p = ua * ub; return p[127:64]; end
            default: begin
                if (w) begin
                    if (b[31:0] == 32'd0) return sel[1] ? sx32(a[31:0]) : '1;
                    s32a = a[31:0]; s32b = b[31:0]; u32a = a[31:0]; u32b = b[31:0];
                    if (!sel[0]) begin
                        if (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                            return sel[1] ? 64'd0 : sx32(a[31:0]);
                        t32 = sel[1] ? s32a % s32b : s32a / s32b;
                    end else begin
                        t32 = sel[1] ? u32a % u32b : u32a / u32b;
                    end
                    return sx32(t32);
                end else begin
                    if (b == 64'd0) return sel[1] ? a : '1;
                    s64a = a; s64b = b; u64a = a; u64b = b;
                    if (!sel[0]) begin
                        if (a == 64'h8000_0000_0000_0000 && b == '1)
                            return sel[1] ? 64'd0 : a;
                        t64 = sel[1] ? s64a % s64b : s64a / s64b;
                    end else begin
                        t64 = sel[1] ? u64a % u64b : u64a / u64b;
                    end
                    return t64;
                end
            end
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] sel, input logic w,
                                     input logic [63:0] a, input logic [63:0] b);
        bit zero, ovf;
        if (!sel[2]) return (sel == 3'd0 && w) ? 33 : 65;
        zero = w ? (b[31:0] == 32'd0) : (b == 64'd0);
        ovf  = !sel[0] && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                             : (a == 64'h8000_0000_0000_0000 && b == '1));
        if (zero || ovf) return 1;
        return w ? 33 : 65;
    endfunction

    // Whenever a result is presented it must be the modelled one, with the input side closed
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            check("mon_result", result, exp_res);
            check("mon_in_ready", 64'(in_ready), 64'd0);
        end
    end

    task automatic do_op(input logic [2:0] sel, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input bit use_lit, input logic [63:0] lit,
                         input int lit_lat, input int hold, input string name);
        logic [63:0] m;
        int ml, lat;
        m  = model(sel, w, a, b);
        ml = model_lat(sel, w, a, b);
        if (use_lit) begin
            check({name, "_model"}, m, lit);
            check({name, "_model_lat"}, 64'(ml), 64'(lit_lat));
        end
        exp_res = m;
        @(posedge clk); #1;
        in_valid = 1'b1; div_sel = sel; is_word = w; src1 = a; src2 = b;
        out_ready = (hold == 0);
        @(negedge clk);
        check({name, "_in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        src1 = {$urandom, $urandom}; src2 = {$urandom, $urandom};
        div_sel = 3'($urandom); is_word = 1'($urandom);
        lat = 0;
        for (int i = 1; i <= 100 && lat == 0; i++) begin
            @(negedge clk);
            if (out_valid) lat = i;
        end
        check({name, "_latency"}, 64'(lat), 64'(ml));
        check({name, "_result"}, result, m);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({name, "_hold_valid"}, 64'(out_valid), 64'd1);
            check({name, "_hold_result"}, result, m);
            check({name, "_hold_in_ready"}, 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check({name, "_back_idle"}, 64'(in_ready), 64'd1);
        check({name, "_valid_low"}, 64'(out_valid), 64'd0);
        last_res = m;
    endtask

    initial begin
        int cnt_v, seen;
        logic [2:0] rs;
        logic rw;
        logic [63:0] ra, rb;
        rst = 1'b0; in_valid = 1'b0; src1 = '0; src2 = '0; div_sel = '0;
        is_word = 1'b0; flush = 1'b0; out_ready = 1'b1;
        #1 rst = 1'b1;
        @(negedge clk);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_result", result, 64'd0);
        @(posedge clk); #1 rst = 1'b0;

        do_op(3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 1, 64'hFFFF_FFFF_FFFF_FFEB, 65, 0, "mul");
        do_op(3'd1, 1'b0, '1, '1, 1, 64'd0, 65, 0, "mulh");
        do_op(3'd3, 1'b0, '1, '1, 1, 64'hFFFF_FFFF_FFFF_FFFE, 65, 0, "mulhu");
        do_op(3'd2, 1'b0, '1, 64'd2, 1, '1, 65, 0, "mulhsu");
        do_op(3'd3, 1'b1, '1, '1, 1, 64'hFFFF_FFFF_FFFF_FFFE, 65, 0, "mulhu_w_ignored");
        do_op(3'd0, 1'b1, 64'h1_0000_0003, 64'hFFFF_FFFF_FFFF_FFFE, 1, 64'hFFFF_FFFF_FFFF_FFFA, 33, 0, "mulw");
        do_op(3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1, 64'hFFFF_FFFF_FFFF_FFFD, 65, 0, "div");
        do_op(3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1, '1, 65, 0, "rem");
        do_op(3'd4, 1'b1, 64'h8000_0000, 64'd1, 1, 64'hFFFF_FFFF_8000_0000, 33, 0, "divw");
        do_op(3'd5, 1'b1, 64'hFFFF_FFFF, 64'd2, 1, 64'h7FFF_FFFF, 33, 0, "divuw");
        do_op(3'd6, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd3, 1, '1, 33, 0, "remw");
        do_op(3'd5, 1'b0, 64'd100, 64'd7, 1, 64'd14, 65, 5, "divu_hold");
        do_op(3'd7, 1'b0, 64'd100, 64'd7, 1, 64'd2, 65, 0, "remu");
        do_op(3'd5, 1'b0, 64'h1234, 64'd0, 1, '1, 1, 0, "divu_by_zero");
        do_op(3'd7, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'd0, 1, 64'h1234_5678_9ABC_DEF0, 1, 0, "remu_by_zero");
        do_op(3'd7, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'd0, 1, 64'hFFFF_FFFF_9ABC_DEF0, 1, 0, "remuw_by_zero");
        do_op(3'd4, 1'b0, 64'd5, 64'd0, 1, '1, 1, 0, "div_by_zero");
        do_op(3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 1, 64'h8000_0000_0000_0000, 1, 0, "div_ovf");
        do_op(3'd6, 1'b0, 64'h8000_0000_0000_0000, '1, 1, 64'd0, 1, 0, "rem_ovf");
        do_op(3'd4, 1'b1, 64'h8000_0000, '1, 1, 64'hFFFF_FFFF_8000_0000, 1, 0, "divw_ovf");

        for (int k = 0; k < 12; k++) begin
            rs = 3'($urandom_range(0, 7));
            rw = 1'($urandom_range(0, 1));
            ra = {$urandom, $urandom};
            rb = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 3)) : {$urandom, $urandom};
            do_op(rs, rw, ra, rb, 0, '0, 0, 0, "random");
        end

        // Flush during the 20th CALC cycle of a divide
        @(posedge clk); #1;
        in_valid = 1'b1; div_sel = 3'd4; is_word = 1'b0; src1 = 64'd1000; src2 = 64'd7;
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (19) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        check("flush_calc_in_ready", 64'(in_ready), 64'd1);
        check("flush_calc_out_valid", 64'(out_valid), 64'd0);
        check("flush_calc_result_kept", result, last_res);
        cnt_v = 0;
        repeat (80) begin
            @(negedge clk);
            if (out_valid) cnt_v++;
        end
        check("flush_calc_never_valid", 64'(cnt_v), 64'd0);

        // Flush coincident with an accept cancels it
        @(posedge clk); #1;
        in_valid = 1'b1; flush = 1'b1; div_sel = 3'd0; src1 = 64'd3; src2 = 64'd5;
        @(posedge clk); #1 in_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("flush_accept_in_ready", 64'(in_ready), 64'd1);
        check("flush_accept_out_valid", 64'(out_valid), 64'd0);

        // Flush while a result is waiting in DONE
        exp_res = 64'd14;
        @(posedge clk); #1;
        in_valid = 1'b1; div_sel = 3'd5; is_word = 1'b0; src1 = 64'd100; src2 = 64'd7;
        out_ready = 1'b0;
        @(posedge clk); #1 in_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 100 && seen == 0; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        check("flush_done_reached", 64'(seen), 64'd1);
        flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("flush_done_out_valid", 64'(out_valid), 64'd0);
        check("flush_done_in_ready", 64'(in_ready), 64'd1);
        check("flush_done_result_kept", result, 64'd14);
        last_res = 64'd14;

        do_op(3'd0, 1'b0, 64'd3, 64'd5, 1, 64'd15, 65, 0, "mul_after_flush");

        // Asynchronous reset in the middle of a multiply
        @(posedge clk); #1;
        in_valid = 1'b1; div_sel = 3'd0; is_word = 1'b0; src1 = 64'd3; src2 = 64'd5;
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("async_rst_in_ready", 64'(in_ready), 64'd1);
        check("async_rst_out_valid", 64'(out_valid), 64'd0);
        check("async_rst_result", result, 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        check("post_rst_out_valid", 64'(out_valid), 64'd0);
        last_res = '0;

        do_op(3'd3, 1'b0, '1, '1, 1, 64'hFFFF_FFFF_FFFF_FFFE, 65, 0, "mulhu_after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
